// File: rtl/aes_pkg.sv
// Shared AES definitions: SubBytes mode encoding and the FIPS-197 forward/inverse S-box tables.
package aes_pkg;

   typedef enum logic {
      SUB_FWD = 1'b0,
      SUB_INV = 1'b1
   } sub_mode_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of SubBytes: combinational lookup in the forward or inverse S-box.
module sbox_lane
   import aes_pkg::*;
(
   input  logic [7:0] din,
   input  sub_mode_e  mode,
   output logic [7:0] dout
);

   always_comb begin
      dout = (mode == SUB_INV) ? INV_SBOX[din] : SBOX[din];
   end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Pipelined multi-lane SubBytes/InvSubBytes with valid/ready on both sides.
// Define SUB_BYTES_BEAT_CNT_EN to add a saturating 32-bit output beat counter (beat_cnt).
module sub_bytes_pipe
   import aes_pkg::*;
#(
   parameter int LANES   = 16,
   parameter int OUT_REG = 1
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_mode,
   input  logic [8*LANES-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_mode,
   output logic [8*LANES-1:0] out_data
`ifdef SUB_BYTES_BEAT_CNT_EN
   ,
   output logic [31:0]        beat_cnt
`endif
);

   // Handshakes: a beat moves across a boundary only on a cycle where valid
   // and ready are both high; a valid stage holds its contents until then.
   logic [8*LANES-1:0] sub_data;
   logic               s1_valid;
   logic               s1_mode;
   logic [8*LANES-1:0] s1_data;
   logic               s1_adv;
   logic               s1_open;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sbox_lane u_lane (
         .din  (in_data[8*i +: 8]),
         .mode (sub_mode_e'(in_mode)),
         .dout (sub_data[8*i +: 8])
      );
   end

   assign s1_open  = ~s1_valid | s1_adv;
   assign in_ready = n_rst & ~clear & s1_open;

   // Stage 1 captures the already-substituted beat.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         s1_valid <= 1'b0;
         s1_mode  <= 1'b0;
         s1_data  <= '0;
      end else if (clear) begin
         s1_valid <= 1'b0;
      end else if (s1_open) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_mode <= in_mode;
            s1_data <= sub_data;
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic               s2_valid;
      logic               s2_mode;
      logic [8*LANES-1:0] s2_data;
      logic               s2_open;

      assign s2_open = ~s2_valid | out_ready;
      assign s1_adv  = s1_valid & s2_open;

      always_ff @(posedge clk) begin
         if (!n_rst) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_data  <= '0;
         end else if (clear) begin
            s2_valid <= 1'b0;
         end else if (s2_open) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_mode <= s1_mode;
               s2_data <= s1_data;
            end
         end
      end

      assign out_valid = s2_valid;
      assign out_mode  = s2_mode;
      assign out_data  = s2_data;
   end else begin : g_no_out_reg
      assign s1_adv    = s1_valid & out_ready;
      assign out_valid = s1_valid;
      assign out_mode  = s1_mode;
      assign out_data  = s1_data;
   end

`ifdef SUB_BYTES_BEAT_CNT_EN
   // Beats discarded by clear are not counted.
   always_ff @(posedge clk) begin
      if (!n_rst || clear) begin
         beat_cnt <= '0;
      end else if (out_valid && out_ready && beat_cnt != 32'hffff_ffff) begin
         beat_cnt <= beat_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Bench for sub_bytes_pipe: vector table, scoreboard queue, backpressure/clear/reset sequences.
module tb_sub_bytes_pipe;

   localparam int LANES = 16;
   localparam int W     = 8 * LANES;

   typedef struct {
      logic         mode;
      logic [W-1:0] din;
      logic [W-1:0] dout;
   } vec_t;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         clear;
   logic         in_valid;
   logic         in_ready;
   logic         in_mode;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_mode;
   logic [W-1:0] out_data;
`ifdef SUB_BYTES_BEAT_CNT_EN
   logic [31:0]  beat_cnt;
`endif

   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   int           stall_cnt = 0;
   logic [7:0]   fwd_tab [256];
   logic [7:0]   inv_tab [256];
   logic [W:0]   exp_q [$];
   int           out_cyc_q [$];
   vec_t         vecs [6];

   sub_bytes_pipe #(.LANES(LANES), .OUT_REG(1)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mode  (out_mode),
      .out_data  (out_data)
`ifdef SUB_BYTES_BEAT_CNT_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
   );

   // Clock and cycle stamp
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference S-box built from GF(2^8) inversion plus the affine transform.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b  = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_tables();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         fwd_tab[x] = s;
         inv_tab[s] = 8'(x);
      end
   endtask

   function automatic logic [W-1:0] model(input logic mode, input logic [W-1:0] d);
      logic [W-1:0] r;
      for (int i = 0; i < LANES; i++)
         r[8*i +: 8] = mode ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
      return r;
   endfunction

   // Scoreboard: pop and compare on every output handshake.
   always @(negedge clk) begin
      if (n_rst && !clear && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat actual=%h required=none", {out_mode, out_data});
         end else begin
            check("scoreboard", {out_mode, out_data}, exp_q.pop_front());
         end
         out_cyc_q.push_back(cyc);
      end
   end

   // Driver: called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic mode, input logic [W-1:0] data, input logic [W-1:0] expd);
      int n = 0;
      in_valid = 1'b1;
      in_mode  = mode;
      in_data  = data;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      stall_cnt += n;
      if (!in_ready) check("send_timeout", W'(in_ready), 1);
      else exp_q.push_back({mode, expd});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain_left", W'(exp_q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      n_rst    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", W'(out_valid), 0);
      check("rst_in_ready", W'(in_ready), 0);
      check("rst_out_data", {1'b0, out_data}, 0);
      check("rst_out_mode", W'(out_mode), 0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(negedge clk);
      check("rst_release_in_ready", W'(in_ready), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] d;
      logic [W-1:0] exp_a;
      int           k;

      vecs[0] = '{1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
      vecs[1] = '{1'b1, {16{8'h63}}, {16{8'h00}}};
      vecs[2] = '{1'b1, {16{8'h00}}, {16{8'h52}}};
      vecs[3] = '{1'b0, {16{8'h00}}, {16{8'h63}}};
      vecs[4] = '{1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
      vecs[5] = '{1'b0, 128'h0f0e0d0c0b0a09080706050403020100, 128'h76abd7fe2b670130c56f6bf27b777c63};

      build_tables();
      in_mode   = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      apply_reset();

      // Latency of the reference vector: out_valid on the second cycle after handshake
      send(vecs[0].mode, vecs[0].din, vecs[0].dout);
      k = 1;
      @(negedge clk);
      while (!out_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("latency", W'(k), 2);
      wait_drain();

      // Table vectors back to back
      for (int i = 0; i < 6; i++) send(vecs[i].mode, vecs[i].din, vecs[i].dout);
      wait_drain();

      // 100 back-to-back beats, alternating mode, against the reference model
      stall_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         send(i[0], d, model(i[0], d));
      end
      check("stream_stalls", W'(stall_cnt), 0);
      wait_drain();
      check("stream_rate", W'(out_cyc_q[out_cyc_q.size()-1] - out_cyc_q[out_cyc_q.size()-100]), 99);

      // Backpressure: two beats fill the pipe, the third waits
      out_ready = 1'b0;
      d = {$urandom, $urandom, $urandom, $urandom};
      exp_a = model(1'b1, d);
      send(1'b1, d, exp_a);
      d = {$urandom, $urandom, $urandom, $urandom};
      send(1'b0, d, model(1'b0, d));
      d = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      in_mode  = 1'b1;
      in_data  = d;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", W'(in_ready), 0);
         check("bp_hold", {out_valid, out_mode, out_data}, {2'b11, exp_a});
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("drain_fill_in_ready", W'(in_ready), 1);
      exp_q.push_back({1'b1, model(1'b1, d)});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_drain();

      // Clear with two beats in flight
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         send(1'b0, d, model(1'b0, d));
      end
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("clear_in_ready", W'(in_ready), 0);
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("clear_out_valid", W'(out_valid), 0);
      out_ready = 1'b1;
      k = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) k++;
      end
      check("clear_no_stale", W'(k), 0);

      // Reset mid-stream with two beats in flight
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         send(1'b1, d, model(1'b1, d));
      end
      n_rst = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(negedge clk);
      check("rst_mid_out_valid", W'(out_valid), 0);
      check("rst_mid_in_ready", W'(in_ready), 1);
      out_ready = 1'b1;
      k = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) k++;
      end
      check("rst_no_stale", W'(k), 0);
      @(posedge clk);
      #1;
      send(vecs[2].mode, vecs[2].din, vecs[2].dout);
      wait_drain();

`ifdef SUB_BYTES_BEAT_CNT_EN
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      for (int i = 0; i < 7; i++) send(vecs[i % 6].mode, vecs[i % 6].din, vecs[i % 6].dout);
      wait_drain();
      check("beat_cnt_7", W'(beat_cnt), 7);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("beat_cnt_clear", W'(beat_cnt), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
